reg_file_wb: RTL
================

Name: reg_file_wb

Overview:
- Write-back stage plus 32-entry register file.
- Consumes the selected write data (PC+4 / ALU result / memory read data) from the write-data mux and commits it through a one-entry staging register.
- Provides two combinational read ports to decode/ALU operand fetch.
- Register ZERO_REG always reads zero and is never written.

Parameters:
DATA_W, 32, register and data width
ADDR_W, 5, register address width (2**ADDR_W entries)
ZERO_REG, 31, index hardwired to zero

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
werf  input  1  write enable for this cycle's write-back
wa  input  ADDR_W  destination register address
wd  input  DATA_W  write data from the write-data mux
ra1  input  ADDR_W  read address, port 1
ra2  input  ADDR_W  read address, port 2
rd1  output  DATA_W  read data, port 1 (combinational)
rd2  output  DATA_W  read data, port 2 (combinational)
pend_vld  output  1  staging register holds an uncommitted write
pend_hit1  output  1  pend_vld and ra1 equals the staged address
pend_hit2  output  1  pend_vld and ra2 equals the staged address

Behaviour:
- Reset (async, any cycle): all array entries = 0, staging cleared (pend_vld=0, staged addr=0, staged data=0). A write mid-flight is discarded. rd1/rd2 then read 0.
- Capture: on a rising edge with werf=1 and wa != ZERO_REG, the staging register loads {wa, wd} and pend_vld=1. Otherwise pend_vld goes to 0 at that edge.
- Commit: on every rising edge with pend_vld=1, array[staged addr] <= staged data. Capture and commit happen on the same edge, so write latency is wd to array = 2 edges.
- Back-to-back writes: the old staged entry commits while the new one is captured; no stall, no loss.
- Same address written on consecutive cycles: the later value wins in the array after the second commit.
- werf=1 with wa=ZERO_REG: no capture; pend_vld falls if nothing new arrives.
- Reads: rd1 is 0 if ra1=ZERO_REG, else array[ra1], subject to the bypass rules under Optional Feature. rd2 follows the same rule with ra2.
- Both ports may read the same address in the same cycle. No port conflicts exist.
- pend_hit1/pend_hit2 are purely combinational from the staging register and ra1/ra2. They are always present; the hazard/stall unit uses them.
- There is no internal backpressure: a write accepted on an edge is always committed on the next edge unless reset asserts.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read whose address hits the staged entry returns the staged data instead of the array. Priority: ZERO_REG, then staging register, then array. Incoming wd is not forwarded in the same cycle.
- Undefined: reads return array contents only. A read during the pending cycle returns the old value, and the pipeline must stall on pend_hit1/pend_hit2.

Test Plan:
- Reset: assert reset asynchronously mid-cycle after writing 0xDEADBEEF to R3 -> rd1 with ra1=3 reads 0 immediately; pend_vld=0.
- Write/read: werf=1, wa=5, wd=0x12345678 at edge 1 -> pend_vld=1, pend_hit1=1 when ra1=5. After edge 2, rd1=0x12345678 and pend_vld=0. In the cycle between edges, rd1=0x12345678 with REGFILE_BYPASS_EN defined, 0 without.
- Zero register: werf=1, wa=31, wd=0xFFFFFFFF -> pend_vld stays 0; rd2 with ra2=31 reads 0 always.
- Back-to-back same address: R7<=0x1 then R7<=0x2 on consecutive edges -> after both commit rd1=0x2. With bypass, rd1 reads 0x1 then 0x2 in the pending cycles.
- Dual port: R1=0xA, R2=0xB committed; ra1=1, ra2=2 -> rd1=0xA, rd2=0xB. Then ra1=ra2=2 -> both read 0xB.
- Reset mid-flight: capture R9<=0x55, assert reset before the commit edge -> R9 reads 0 after release; pend_vld=0.

Source files
------------

// File: rtl/reg_file_wb.sv
// ============================================================================
// Module   : reg_file_wb
// Brief    : Write-back staging register plus 32-entry register file with two
//            combinational read ports. Optional macro REGFILE_BYPASS_EN
//            forwards the staged write to the read ports.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_file_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              werf,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              pend_vld,
    output logic              pend_hit1,
    output logic              pend_hit2
);

    localparam int                NREGS     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [NREGS];

    logic              pend_vld_q,  pend_vld_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic              capture;

    // Writes to the zero register are dropped here so it never reaches the array.
    always_comb begin
        capture     = werf && (wa != ZERO_ADDR);
        pend_vld_d  = capture;
        pend_addr_d = capture ? wa : pend_addr_q;
        pend_data_d = capture ? wd : pend_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (pend_vld_q) begin
            regs_q[pend_addr_q] <= pend_data_q;
        end
    end

    assign pend_hit1 = pend_vld_q && (ra1 == pend_addr_q);
    assign pend_hit2 = pend_vld_q && (ra2 == pend_addr_q);
    assign pend_vld  = pend_vld_q;

    always_comb begin
        rd1 = regs_q[ra1];
        rd2 = regs_q[ra2];
`ifdef REGFILE_BYPASS_EN
        if (pend_hit1) rd1 = pend_data_q;
        if (pend_hit2) rd2 = pend_data_q;
`endif
        if (ra1 == ZERO_ADDR) rd1 = '0;
        if (ra2 == ZERO_ADDR) rd2 = '0;
    end

endmodule

`default_nettype wire
